// File: rtl/spi2apb_bridge_v2.sv
// SPI-slave to APB-master bridge: one framed SPI transfer becomes one APB
// access to one of NUM_BANKS slaves, with wait states, timeout and error flag.
module spi2apb_bridge_v2 #(
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int TA_BITS    = 4
) (
    input  logic                  sclk,
    input  logic                  resetn,
    input  logic                  mosi,
    input  logic                  ss,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] b_prdata,
    input  logic                  b_pready,
    input  logic                  b_pslverr,
    output logic                  b_pclk,
    output logic                  b_presetn,
    output logic [DATA_WIDTH-1:0] b_pwdata,
    output logic                  b_pwrite,
    output logic [NUM_BANKS-1:0]  b_psel,
    output logic                  b_penable,
    output logic [ADDR_WIDTH-1:0] b_paddr
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int H      = 1 + BANK_W + ADDR_WIDTH;
    localparam int D      = DATA_WIDTH;
    localparam int F      = H + D + TA_BITS;
    localparam int CW     = $clog2(F + 1);
    localparam int EW     = $clog2(TA_BITS + 1);
    localparam int SW     = H + D - 1;

    localparam logic [CW-1:0]     C_RD_E0 = CW'(H - 1);
    localparam logic [CW-1:0]     C_WR_E0 = CW'(H + D - 1);
    localparam logic [CW-1:0]     C_LOAD  = CW'(H + TA_BITS - 1);
    localparam logic [CW-1:0]     C_SRMAX = CW'(H + D);
    localparam logic [CW-1:0]     C_F     = CW'(F);
    localparam logic [EW-1:0]     E_TA    = EW'(TA_BITS);
    localparam logic [BANK_W:0]   NB      = NUM_BANKS[BANK_W:0];

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [EW-1:0]       ecnt;
    logic                rw_q;
    logic [SW-1:0]       sr;
    logic [SW-1:0]       sr_n;
    logic [D-1:0]        rdata;
    logic [D-1:0]        sh;
    logic [D-1:0]        sh_n;
    logic [D-1:0]        rd_src;
    logic                err;
    logic                err_n;

    logic                active;
    logic                e0;
    logic [H-2:0]        hdr;
    logic [BANK_W-1:0]   bank;
    logic [ADDR_WIDTH-1:0] addr;
    logic [D-1:0]        wdat;
    logic                bad;
    logic [NUM_BANKS-1:0] onehot;
    logic                timeout;
    logic                done;
    logic                load;
    logic                shift;

    assign b_pclk    = sclk;
    assign b_presetn = resetn;

    assign active = ~ss && (cnt != C_F);

    // The R/W bit is kept in rw_q, so the shifter only holds bank/addr/data.
    always_comb begin
        sr_n = sr;
        if (active && (cnt != '0) && (cnt < C_SRMAX))
            sr_n = {sr[SW-2:0], mosi};
    end

    assign hdr  = rw_q ? sr_n[SW-1 -: H-1] : sr_n[H-2:0];
    assign bank = hdr[H-2 -: BANK_W];
    assign addr = hdr[ADDR_WIDTH-1:0];
    assign wdat = sr_n[D-1:0];
    assign bad  = ({1'b0, bank} >= NB);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            onehot[i] = (BANK_W'(i) == bank);
    end

    assign e0 = active && (state == IDLE) &&
                ((rw_q && (cnt == C_WR_E0)) ||
                 (!rw_q && (cnt == C_RD_E0)));

    assign timeout = (state == ACCESS) && (ecnt == E_TA);
    assign done    = (state == ACCESS) && (ecnt != E_TA) && b_pready;

    // A flag-set on the frame's first edge must beat the read-clear.
    always_comb begin
        err_n = err;
        if (~ss && (cnt == '0))
            err_n = 1'b0;
        if ((e0 && bad) || timeout || (done && b_pslverr))
            err_n = 1'b1;
    end

    always_ff @(posedge sclk) begin
        if (!resetn) begin
            cnt  <= '0;
            rw_q <= 1'b0;
            sr   <= '0;
            err  <= 1'b0;
        end else begin
            err <= err_n;
            sr  <= sr_n;
            if (ss)
                cnt <= '0;
            else if (cnt != C_F)
                cnt <= cnt + 1'b1;
            if (~ss && (cnt == '0))
                rw_q <= mosi;
        end
    end

    always_ff @(posedge sclk) begin
        if (!resetn) begin
            state     <= IDLE;
            ecnt      <= '0;
            rdata     <= '0;
            b_psel    <= '0;
            b_penable <= 1'b0;
            b_paddr   <= '0;
            b_pwrite  <= 1'b0;
            b_pwdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (e0)
                        rdata <= '0;
                    if (e0 && !bad) begin
                        state     <= SETUP;
                        ecnt      <= EW'(1);
                        b_psel    <= onehot;
                        b_paddr   <= addr;
                        b_pwrite  <= rw_q;
                        b_pwdata  <= rw_q ? wdat : '0;
                        b_penable <= 1'b0;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    ecnt      <= EW'(2);
                    b_penable <= 1'b1;
                end
                ACCESS: begin
                    if (timeout || done) begin
                        state     <= IDLE;
                        b_psel    <= '0;
                        b_penable <= 1'b0;
                        b_paddr   <= '0;
                        b_pwrite  <= 1'b0;
                        b_pwdata  <= '0;
                        if (done && !b_pwrite)
                            rdata <= b_prdata;
                    end else begin
                        ecnt <= ecnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign load  = ~ss && !rw_q && (cnt == C_LOAD);
    assign shift = ~ss && !rw_q && (cnt > C_LOAD) && (cnt < C_F);

    assign rd_src = timeout ? '0 : rdata;

    always_comb begin
        sh_n = sh;
        if (load)
            sh_n = rd_src;
        else if (shift)
            sh_n = {sh[D-2:0], 1'b0};
    end

    always_ff @(posedge sclk) begin
        if (!resetn) begin
            sh   <= '0;
            miso <= 1'b0;
        end else begin
            sh <= sh_n;
            if (ss)
                miso <= err_n;
            else if (load || shift)
                miso <= sh_n[D-1];
            else
                miso <= 1'b0;
        end
    end

endmodule
